// File: rtl/matrix_row_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : matrix_row_scheduler
// Function : Walks a latched square matrix through an external row unit,
//            one masked row per cycle, and assembles the result matrix.
// Revision : 1.0 - initial release
// ============================================================================
module matrix_row_scheduler #(
    parameter int  ELEM_W = 8,
    parameter int  MAX_N  = 5,
    localparam int ROW_W  = ELEM_W * MAX_N,
    localparam int MAT_W  = ROW_W * MAX_N
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       m_size,
    input  logic [MAT_W-1:0] mat_in,
    output logic [ROW_W-1:0] row_to_unit,
    input  logic [ROW_W-1:0] row_from_unit,
    input  logic             unit_ovf,
    output logic [MAT_W-1:0] mat_out,
    output logic             ovf,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;
    localparam logic [2:0] c_MAX_N = 3'(MAX_N);

    logic [1:0]       r_state;
    logic [MAT_W-1:0] r_mat;
    logic [MAT_W-1:0] r_mat_out;
    logic [2:0]       r_n;
    logic [2:0]       r_row;
    logic             r_ovf;
    logic             r_busy;
    logic             r_done;
    logic             r_err;

    logic [ROW_W-1:0] w_col_mask;
    logic [ROW_W-1:0] w_row_sel;
    logic             w_size_ok;
    logic             w_last;

    // Element c occupies the c-th ELEM_W slice counting down from the row MSB.
    for (genvar c = 0; c < MAX_N; c++) begin : g_mask
        assign w_col_mask[ROW_W-1-c*ELEM_W -: ELEM_W] =
            {ELEM_W{(3'(c) < r_n)}};
    end

    always_comb begin
        w_row_sel = '0;
        for (int i = 0; i < MAX_N; i++) begin
            if (r_row == 3'(i)) begin
                w_row_sel = r_mat[MAT_W-1-i*ROW_W -: ROW_W];
            end
        end
    end

    assign w_size_ok   = (m_size >= 3'd2) && (m_size <= c_MAX_N);
    assign w_last      = (r_row == (r_n - 3'd1));
    assign row_to_unit = (r_state == c_RUN) ? (w_row_sel & w_col_mask) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_mat     <= '0;
            r_mat_out <= '0;
            r_n       <= '0;
            r_row     <= '0;
            r_ovf     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_done <= 1'b0;
                    r_err  <= 1'b0;
                    if (start) begin
                        r_mat     <= mat_in;
                        r_n       <= m_size;
                        r_row     <= '0;
                        r_mat_out <= '0;
                        r_ovf     <= 1'b0;
                        if (w_size_ok) begin
                            r_state <= c_RUN;
                            r_busy  <= 1'b1;
                        end else begin
                            // Bad size: report immediately, no row is ever presented.
                            r_state <= c_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end
                    end
                end
                c_RUN: begin
                    for (int i = 0; i < MAX_N; i++) begin
                        if (r_row == 3'(i)) begin
                            r_mat_out[MAT_W-1-i*ROW_W -: ROW_W] <= row_from_unit & w_col_mask;
                        end
                    end
                    r_ovf <= r_ovf | unit_ovf;
                    r_row <= r_row + 3'd1;
                    if (w_last) begin
                        r_state <= c_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_err   <= 1'b0;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                    r_done  <= 1'b0;
                    r_err   <= 1'b0;
                end
                default: begin
                    r_state <= c_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_err   <= 1'b0;
                end
            endcase
        end
    end

    assign mat_out = r_mat_out;
    assign ovf     = r_ovf;
    assign busy    = r_busy;
    assign done    = r_done;
    assign err     = r_err;

endmodule
`default_nettype wire

// File: doc/matrix_row_scheduler.md
Name: matrix_row_scheduler

Overview:
- Sequences a row-wise matrix datapath unit (per-row element op, e.g. the negation/opposite unit) over a full square matrix, one row per cycle.
- Latches a packed matrix on start and presents each active row to the external unit, masking columns outside the active size.
- Captures each result row and its overflow flag, assembles the output matrix and pulses done.
- Sits between the coprocessor instruction decoder/register bank and the row unit.

Parameters:
ELEM_W, 8, signed element width in bits
MAX_N, 5, maximum matrix dimension; ROW_W = ELEM_W*MAX_N (40), MAT_W = ROW_W*MAX_N (200)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
start  input  1  request to process mat_in; sampled only in IDLE
m_size  input  3  matrix dimension N; valid range 2..MAX_N
mat_in  input  MAT_W  packed source matrix; row 0 in MSBs, element 0 in MSBs of each row
row_to_unit  output  ROW_W  row presented to the row unit (combinational unit, same-cycle result)
row_from_unit  input  ROW_W  result row from the unit
unit_ovf  input  1  overflow flag from the unit for the presented row
mat_out  output  MAT_W  assembled result matrix, same packing as mat_in
ovf  output  1  sticky OR of unit_ovf over all processed rows
busy  output  1  high from accept until done
done  output  1  one-cycle completion pulse
err  output  1  one-cycle pulse with done when m_size is invalid

Behaviour:
- Reset (synchronous, rst=1 at an edge): state IDLE; mat_out=0, ovf=0, busy=0, done=0, err=0, row index=0, internal matrix latch=0. Reset overrides start and any operation in progress; an aborted job produces no done.
- States are IDLE, RUN, DONE.
- IDLE: row_to_unit=0. When start=1 at edge k, the block latches mat_in and N, clears mat_out and ovf, and sets busy=1.
  - If N is in 2..MAX_N, the next state is RUN with row index 0.
  - Otherwise (N=0, 1, 6 or 7), the next state is DONE with err pending.
- RUN, row index r: row_to_unit = latched row r with elements of index >= N forced to 0.
  - At each edge, row_from_unit is written to mat_out row r, with elements >= N forced to 0.
  - At the same edge, ovf <= ovf | unit_ovf, and r increments.
  - The edge that captures r = N-1 moves the state to DONE.
- DONE (one cycle): done=1, err=1 only for an invalid size, busy=0, row_to_unit=0. The next state is IDLE.
- Latency: start accepted at edge k; rows presented in cycles k+1..k+N; done high in cycle k+N+1. Invalid size gives done and err in cycle k+1.
- Rows with index >= N are never presented; their mat_out rows stay 0.
- mat_out and ovf hold their values after DONE until the next accepted start or reset.
- start while busy, or during the DONE cycle, is ignored; it is not queued. start held high continuously re-triggers only from IDLE.
- mat_in and m_size changes after accept have no effect on the running job.
- unit_ovf is sampled only in RUN; it is ignored in IDLE and DONE.
- No arithmetic is performed in this block; the element bits of row_from_unit are passed through unmodified except for column masking.

Test Plan:
1. N=5, rows [1,3,2,5,0],[−1,−3,−2,−5,0],[4,4,4,4,4],[0..0],[7,−7,1,−1,0], bench negation model. Expected: the negated matrix, ovf=0, done in cycle k+6, and row_to_unit sequence matching rows 0..4.
2. N=5, row 2 = [−128,0,0,0,0], model asserts unit_ovf for that row. Expected: mat_out row 2 = [−128,0,0,0,0], ovf=1 after done, and ovf stays 1 until the next start.
3. N=3, all elements 9. Expected: row_to_unit = [9,9,9,0,0] for 3 cycles, mat_out rows 0..2 = [−9,−9,−9,0,0], rows 3..4 = 0, done in cycle k+4.
4. N=6, then N=1. Expected: done=err=1 in cycle k+1, mat_out=0, ovf=0, no row presented.
5. start pulsed in cycles k+2 and k+N+1 of an N=4 job with changed mat_in. Expected: a single done, and results from the original mat_in.
6. rst=1 in cycle k+3 of an N=5 job. Expected: next cycle IDLE with mat_out=0, ovf=0, busy=0, and no done pulse; a following start completes normally.
